// File: rtl/q_channel_device.sv
// Device-side Q-channel controller: quiesces the device on QREQn, then accepts
// (QACCEPTn low, device stopped) or denies (QDENY) the low-power request.
module q_channel_device #(
  parameter int IDLE_CYCLES  = 4,
  parameter int DENY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qreqn_sync,
  input  logic       busy,
  input  logic       wake,
  output logic       qacceptn,
  output logic       qdeny,
  output logic       qactive,
  output logic       dev_stopped,
  output logic       proto_err,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(DENY_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] DENY_LAST = CW'(DENY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    REQUEST  = 3'd1,
    STOPPED  = 3'd2,
    EXIT     = 3'd3,
    DENIED   = 3'd4,
    CONTINUE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          qacceptn_q, qacceptn_d;
  logic          qdeny_q, qdeny_d;
  logic          qactive_q;
  logic          dev_stopped_q, dev_stopped_d;
  logic          proto_err_q, proto_err_d;
  logic          dev_quiet;

  // Next-state, counter and output decode; outputs follow the next state so
  // they change on the same edge as state_o.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    proto_err_d = 1'b0;
    dev_quiet   = ~busy & ~wake;

    case (state_q)
      RUN: begin
        if (!qreqn_sync) begin
          state_d    = REQUEST;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      REQUEST: begin
        if (qreqn_sync) begin
          // Controller withdrew QREQn before we answered.
          state_d     = RUN;
          idle_cnt_d  = '0;
          wait_cnt_d  = '0;
          proto_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (dev_quiet) begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end else begin
            idle_cnt_d = '0;
          end
          if (dev_quiet && (idle_cnt_q == IDLE_LAST)) begin
            state_d = STOPPED;
          end else if (wait_cnt_q == DENY_LAST) begin
            state_d = DENIED;
          end else begin
            state_d = REQUEST;
          end
        end
      end
      STOPPED: begin
        if (qreqn_sync) begin
          state_d = EXIT;
        end else begin
          state_d = STOPPED;
        end
      end
      EXIT: begin
        state_d = RUN;
      end
      DENIED: begin
        if (qreqn_sync) begin
          state_d = CONTINUE;
        end else begin
          state_d = DENIED;
        end
      end
      CONTINUE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    qacceptn_d    = ~((state_d == STOPPED) || (state_d == EXIT));
    qdeny_d       = (state_d == DENIED) || (state_d == CONTINUE);
    dev_stopped_d = (state_d == STOPPED);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      idle_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      qacceptn_q    <= 1'b1;
      qdeny_q       <= 1'b0;
      qactive_q     <= 1'b0;
      dev_stopped_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      qacceptn_q    <= qacceptn_d;
      qdeny_q       <= qdeny_d;
      qactive_q     <= busy | wake;
      dev_stopped_q <= dev_stopped_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign qacceptn    = qacceptn_q;
  assign qdeny       = qdeny_q;
  assign qactive     = qactive_q;
  assign dev_stopped = dev_stopped_q;
  assign proto_err   = proto_err_q;
  assign state_o     = state_q;

endmodule

// File: doc/q_channel_device.md
# q_channel_device

Device-side Q-channel low-power handshake controller. It consumes the synchronized QREQn produced by the `dff` synchronizer stage and quiesces the local device. It then either accepts the request, asserting QACCEPTn low and the stop indication, or denies it with QDENY. It also drives QACTIVE from device activity, so the power controller can see pending work.

## Interface
Parameters:
- IDLE_CYCLES, default 4: consecutive idle samples required in REQUEST before accepting. Must be ≥1.
- DENY_TIMEOUT, default 16: cycles spent in REQUEST before denying. Must be > IDLE_CYCLES.

Ports:
- clk  in  1  single clock; everything is in this domain.
- reset  in  1  synchronous, active-low reset.
- qreqn_sync  in  1  QREQn, already synchronized into clk by the `dff` stage (that stage resets to 1).
- busy  in  1  device has outstanding transactions.
- wake  in  1  device-internal wake/work request.
- qacceptn  out  1  Q-channel QACCEPTn.
- qdeny  out  1  Q-channel QDENY.
- qactive  out  1  Q-channel QACTIVE.
- dev_stopped  out  1  high while the device may be clock-gated or powered down.
- proto_err  out  1  one-cycle pulse on a controller protocol violation.
- state_o  out  3  current state, for debug.

## Operation
- States and encodings: RUN=0, REQUEST=1, STOPPED=2, EXIT=3, DENIED=4, CONTINUE=5. Encodings 6 and 7 are illegal and go to RUN on the next edge.
- All outputs are registered and update on the same edge as the state.
- Reset values, with reset=0 sampled at an edge: state RUN, qacceptn=1, qdeny=0, qactive=0, dev_stopped=0, proto_err=0, both counters 0.
- Reset has priority over every transition at any point in a handshake.
- Two counters, each `$clog2(DENY_TIMEOUT+1)` bits wide:
  - idle_cnt counts consecutive cycles with busy=0 and wake=0.
  - wait_cnt counts cycles spent in REQUEST.
- RUN:
  - If qreqn_sync=0, go to REQUEST and clear both counters.
  - Otherwise stay in RUN.
- REQUEST:
  - Each cycle, wait_cnt increments.
  - idle_cnt increments if busy=0 and wake=0; otherwise it clears to 0.
  - Accept: if busy=0, wake=0 and idle_cnt==IDLE_CYCLES-1, go to STOPPED with qacceptn←0 and dev_stopped←1.
  - Deny: else if wait_cnt==DENY_TIMEOUT-1, go to DENIED with qdeny←1.
  - Accept beats deny when both conditions hold in the same cycle.
  - Withdrawal: if qreqn_sync=1 in REQUEST, this is a protocol violation. Go to RUN, clear the counters and pulse proto_err. Withdrawal has priority over accept and deny.
- STOPPED:
  - qacceptn=0 and dev_stopped=1.
  - If qreqn_sync=1, go to EXIT with dev_stopped←0; qacceptn stays 0.
  - busy and wake are ignored here, except through qactive.
- EXIT: unconditionally go to RUN with qacceptn←1.
- DENIED:
  - qdeny=1.
  - If qreqn_sync=1, go to CONTINUE; qdeny stays 1.
- CONTINUE: unconditionally go to RUN with qdeny←0.
- qactive is registered as busy | wake in every state, including during reset release. It is the only output that does not depend on state.
- qacceptn=0 and qdeny=1 are never asserted together.

## Timing
- Edge numbering: qreqn_sync is first sampled low at edge k.
- REQUEST entry: state_o=1 after edge k.
- Fastest accept: with busy=wake=0 throughout, qacceptn falls and dev_stopped rises after edge k+IDLE_CYCLES.
- Deny: with busy held high, qdeny rises after edge k+DENY_TIMEOUT.
- Exit from STOPPED: qreqn_sync is first sampled high at edge m.
  - dev_stopped falls after edge m.
  - qacceptn rises after edge m+1.
  - The device therefore gets one ungated cycle before the handshake completes.
- Exit from DENIED: qreqn_sync is first sampled high at edge m; qdeny falls after edge m+1.
- Back-to-back requests: once in RUN, a low qreqn_sync sampled on the following edge starts a new REQUEST.
- proto_err is high for exactly the one cycle after the violating edge.

## Test plan
- Clean accept: IDLE_CYCLES=4, busy=wake=0, qreqn_sync falls at edge 10 → qacceptn=0 and dev_stopped=1 after edge 14. Raise qreqn_sync at edge 20 → dev_stopped=0 after edge 20, qacceptn=1 after edge 21, state RUN.
- Busy resets the idle count: busy=1 during edges 11–12 of a request that starts at edge 10 → accept occurs after edge 16, not edge 14.
- Deny: DENY_TIMEOUT=16, busy held at 1, request at edge 10 → qdeny=1 after edge 26, qacceptn stays 1. qreqn_sync high at edge 30 → state CONTINUE after edge 30, qdeny=0 after edge 31.
- Accept/deny tie: IDLE_CYCLES=4, DENY_TIMEOUT=5, busy=1 for the first cycle only → accept wins, qdeny never asserts.
- Withdrawal: qreqn_sync high after 2 cycles in REQUEST → proto_err pulses for 1 cycle, state RUN, qacceptn=1, qdeny=0.
- Reset mid-handshake: reset=0 sampled while in STOPPED (and separately in DENIED) → after that edge, state RUN, qacceptn=1, qdeny=0, dev_stopped=0. Then qreqn_sync low after reset release → REQUEST on the next edge.
